// File: rtl/progmem_loader.sv
// Program memory for the fetch stage with a host-driven boot loader.
// The core is held off while loading and flushed for one cycle when the new program is released.
module progmem_loader #(
   parameter int INST_W      = 32,
   parameter int INST_ADDR_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INST_ADDR_W-1:0] progmem_addr,
   output logic [INST_W-1:0]      progmem_data,
   input  logic                   load_start,
   input  logic                   load_valid,
   input  logic [INST_W-1:0]      load_data,
   input  logic                   load_last,
   output logic                   load_ready,
   output logic                   core_en,
   output logic                   core_flush,
   output logic                   load_busy,
   output logic                   load_full,
   output logic [INST_ADDR_W:0]   loaded_words
);
   localparam int DEPTH = 2**INST_ADDR_W;

   typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

   state_t                 state;
   logic [INST_ADDR_W-1:0] wr_ptr;
   logic [INST_W-1:0]      mem [DEPTH];
   logic                   hs;
   logic                   last_slot;

   assign hs        = load_valid & load_ready;
   assign last_slot = (wr_ptr == INST_ADDR_W'(DEPTH-1));

   // core_en is high exactly in RELEASE/RUN, so it doubles as the read-port gate.
   assign progmem_data = core_en ? mem[progmem_addr] : '0;

   // The array has no reset; a reset mid-load keeps the words already written.
   always_ff @(posedge clk) begin
      if (!rst && hs)
         mem[wr_ptr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         core_en      <= 1'b0;
         core_flush   <= 1'b0;
         load_ready   <= 1'b0;
         load_busy    <= 1'b0;
         load_full    <= 1'b0;
         loaded_words <= '0;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (load_start) begin
                  state        <= LOAD;
                  wr_ptr       <= '0;
                  loaded_words <= '0;
                  load_full    <= 1'b0;
                  load_ready   <= 1'b1;
                  load_busy    <= 1'b1;
                  core_en      <= 1'b0;
                  core_flush   <= 1'b0;
               end
            end
            LOAD: begin
               if (hs) begin
                  loaded_words <= loaded_words + 1'b1;
                  // wr_ptr parks at the last slot; the capacity exit below stops the load
                  if (!last_slot)
                     wr_ptr <= wr_ptr + 1'b1;
                  if (load_last || last_slot) begin
                     state      <= RELEASE;
                     load_full  <= last_slot & ~load_last;
                     load_ready <= 1'b0;
                     load_busy  <= 1'b0;
                     core_en    <= 1'b1;
                     core_flush <= 1'b1;
                  end
               end
            end
            RELEASE: begin
               state      <= RUN;
               core_flush <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_progmem_loader.sv
// Directed bench for progmem_loader: load, gating, capacity exit, reload and mid-load reset.
module tb_progmem_loader;
   localparam int W  = 32;
   localparam int AW = 4;
   localparam int D  = 2**AW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] progmem_addr;
   logic [W-1:0]  progmem_data;
   logic          load_start, load_valid, load_last;
   logic [W-1:0]  load_data;
   logic          load_ready, core_en, core_flush, load_busy, load_full;
   logic [AW:0]   loaded_words;

   int checks = 0;
   int errors = 0;

   progmem_loader #(.INST_W(W), .INST_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .progmem_addr(progmem_addr), .progmem_data(progmem_data),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .core_en(core_en),
      .core_flush(core_flush), .load_busy(load_busy), .load_full(load_full),
      .loaded_words(loaded_words)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
      progmem_addr = a;
      #1;
      check(tag, progmem_data, exp);
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_data = '0; progmem_addr = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // 1: reset state
      check("rst_core_en", core_en, 0);
      check("rst_flush", core_flush, 0);
      check("rst_ready", load_ready, 0);
      check("rst_busy", load_busy, 0);
      check("rst_full", load_full, 0);
      check("rst_words", loaded_words, 0);
      rd("rst_data5", 5, 0);
      rd("rst_data0", 0, 0);

      // 2: basic three-word load
      start();
      check("ld_ready", load_ready, 1);
      check("ld_busy", load_busy, 1);
      check("ld_core_en", core_en, 0);
      send(32'h11, 0); send(32'h22, 0); send(32'h33, 1);
      check("rel_core_en", core_en, 1);
      check("rel_flush", core_flush, 1);
      check("rel_ready", load_ready, 0);
      check("rel_words", loaded_words, 3);
      check("rel_full", load_full, 0);
      rd("rel_a2", 2, 32'h33);
      tick();
      check("run_flush", core_flush, 0);
      check("run_core_en", core_en, 1);
      rd("run_a0", 0, 32'h11);
      rd("run_a1", 1, 32'h22);

      // 3: gapped valid, only handshakes write
      start();
      send(32'h44, 0);
      tick();
      send(32'h55, 0);
      tick();
      send(32'h66, 1);
      check("gap_words", loaded_words, 3);
      check("gap_flush", core_flush, 1);
      rd("gap_a0", 0, 32'h44);
      rd("gap_a1", 1, 32'h55);
      rd("gap_a2", 2, 32'h66);
      tick();

      // 4: capacity exit; a load_start mid-load must be ignored
      start();
      for (int i = 0; i < D; i++) begin
         load_start = (i == 5);
         send(W'(32'h100 + i), 0);
         load_start = 1'b0;
      end
      check("cap_full", load_full, 1);
      check("cap_words", loaded_words, D);
      check("cap_flush", core_flush, 1);
      rd("cap_a0", 0, 32'h100);
      rd("cap_a5", 5, 32'h105);
      rd("cap_a15", 15, 32'h10f);
      tick();

      // 5: reload from RUN
      check("rl_pre_en", core_en, 1);
      progmem_addr = 0;
      start();
      check("rl_core_en", core_en, 0);
      check("rl_busy", load_busy, 1);
      check("rl_full_clr", load_full, 0);
      rd("rl_nop", 0, 0);
      send(32'hAA, 1);
      check("rl_words", loaded_words, 1);
      check("rl_full", load_full, 0);
      rd("rl_a0", 0, 32'hAA);
      rd("rl_a1", 1, 32'h101);
      tick();

      // 6: reset mid-load
      start();
      send(32'hB1, 0); send(32'hB2, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_core_en", core_en, 0);
      check("mr_busy", load_busy, 0);
      check("mr_ready", load_ready, 0);
      rd("mr_nop", 1, 0);
      tick();
      check("mr_idle_en", core_en, 0);
      start();
      send(32'hC1, 1);
      check("mr_words", loaded_words, 1);
      check("mr_flush", core_flush, 1);
      rd("mr_a0", 0, 32'hC1);
      rd("mr_a1", 1, 32'hB2);
      tick();
      check("mr_run_flush", core_flush, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
